data_gen_burst_sched: RTL and testbench

- Controller that sequences a streaming data generator (ap_ctrl_hs slave, `size` in beats) for one large transfer.
- Splits a job of total_beats into bursts bounded by max_burst and the 4 KiB address boundary.
- For each burst, issues a write-address command to the downstream AXI-MM writer, then starts the generator for that burst length.
- Exposes its own ap_ctrl_hs interface to the host/testbench.

---
 rtl/data_gen_burst_sched_if.sv | 34 +++
 rtl/data_gen_burst_sched.sv | 103 ++++++++++
 tb/tb_data_gen_burst_sched.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_gen_burst_sched_if.sv
// Host, AXI-MM write-command and generator handshakes of the burst scheduler.
// slave = scheduler side, master = host/environment side.
interface data_gen_burst_sched_if #(
    parameter int ADDR_W = 32
);
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       total_beats;
    logic [15:0]       max_burst;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_beats;
    logic              gen_start;
    logic              gen_ready;
    logic              gen_done;
    logic [31:0]       gen_size;
    logic [31:0]       beats_done;

    modport slave (
        input  ap_start, base_addr, total_beats, max_burst, wr_ready, gen_ready, gen_done,
        output ap_ready, ap_done, ap_idle, wr_valid, wr_addr, wr_beats, gen_start,
               gen_size, beats_done
    );

    modport master (
        output ap_start, base_addr, total_beats, max_burst, wr_ready, gen_ready, gen_done,
        input  ap_ready, ap_done, ap_idle, wr_valid, wr_addr, wr_beats, gen_start,
               gen_size, beats_done
    );
endinterface

// File: rtl/data_gen_burst_sched.sv
// Splits one job into bursts capped by max_burst and the 4 KiB boundary; for
// each burst issues a write command, then runs the generator for that length.
module data_gen_burst_sched #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 256
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    data_gen_burst_sched_if.slave bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, CALC, CMD, GEN_START, GEN_WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       remaining;
    logic [15:0]       cap, len;
    logic [12:0]       to4k;
    logic [15:0]       cap_to, len_calc;
    logic              accept, complete;

    // Beats left before the next 4 KiB page; never zero since addr is BYTES-aligned.
    assign to4k     = 13'(13'd4096 - {1'b0, addr[11:0]}) >> SHIFT;
    assign cap_to   = (cap < 16'(to4k)) ? cap : 16'(to4k);
    assign len_calc = (remaining < 32'(cap_to)) ? remaining[15:0] : cap_to;

    always_comb begin
        state_nxt    = state;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        bus.ap_idle  = 1'b0;
        bus.wr_valid = 1'b0;
        bus.gen_start = 1'b0;
        accept       = 1'b0;
        complete     = 1'b0;
        case (state)
            IDLE: begin
                bus.ap_idle = 1'b1;
                if (bus.ap_start) begin
                    bus.ap_ready = 1'b1;
                    accept       = 1'b1;
                    state_nxt    = (bus.total_beats == 32'd0) ? DONE : CALC;
                end
            end
            CALC: state_nxt = CMD;
            CMD: begin
                bus.wr_valid = 1'b1;
                if (bus.wr_ready) state_nxt = GEN_START;
            end
            GEN_START: begin
                bus.gen_start = 1'b1;
                if (bus.gen_ready) begin
                    if (bus.gen_done) complete  = 1'b1;
                    else              state_nxt = GEN_WAIT;
                end
            end
            GEN_WAIT: if (bus.gen_done) complete = 1'b1;
            DONE: begin
                bus.ap_done = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (complete) state_nxt = (remaining == 32'(len)) ? DONE : CALC;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            cap            <= '0;
            len            <= '0;
            bus.wr_addr    <= '0;
            bus.wr_beats   <= '0;
            bus.gen_size   <= '0;
            bus.beats_done <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr           <= bus.base_addr;
                remaining      <= bus.total_beats;
                bus.beats_done <= '0;
                cap <= (bus.max_burst == 16'd0 || 32'(bus.max_burst) > MAX_BURST)
                       ? 16'(MAX_BURST) : bus.max_burst;
            end
            if (state == CALC) begin
                len          <= len_calc;
                bus.wr_addr  <= addr;
                bus.wr_beats <= len_calc;
                bus.gen_size <= 32'(len_calc);
            end
            if (complete) begin
                addr           <= addr + (ADDR_W'(len) << SHIFT);
                remaining      <= remaining - 32'(len);
                bus.beats_done <= bus.beats_done + 32'(len);
            end
        end
    end
endmodule

// File: tb/tb_data_gen_burst_sched.sv
// Randomized bench for data_gen_burst_sched; a burst-list model predicts every
// command and the cycle-exact handshake sequence of each job.
module tb_data_gen_burst_sched;
    localparam int BYTES = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_len[$];

    always #5 ap_clk = ~ap_clk;

    data_gen_burst_sched_if #(.ADDR_W(32)) bus ();

    data_gen_burst_sched #(.WIDTH(32), .ADDR_W(32), .MAX_BURST(256)) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus)
    );

    // Burst list from the splitting rules: min(remaining, cap, beats to 4 KiB).
    task automatic build_model(input logic [31:0] base, input logic [31:0] total,
                               input logic [15:0] mb);
        logic [31:0] a, rem, cap, to4k, len;
        exp_addr.delete();
        exp_len.delete();
        cap = (mb == 16'd0 || mb > 16'd256) ? 32'd256 : {16'd0, mb};
        a   = base;
        rem = total;
        while (rem != 0) begin
            to4k = (32'd4096 - (a % 32'd4096)) / BYTES;
            len  = rem;
            if (cap < len)  len = cap;
            if (to4k < len) len = to4k;
            exp_addr.push_back(a);
            exp_len.push_back(len);
            a   = a + len * BYTES;
            rem = rem - len;
        end
    endtask

    task automatic run_job(input logic [31:0] base, input logic [31:0] total,
                           input logic [15:0] mb, input int w_lo, input int w_hi,
                           input int g_lo, input int g_hi, input int same_mode,
                           input string tag);
        int d;
        bit same, last;
        logic [31:0] acc, len;
        build_model(base, total, mb);
        @(negedge ap_clk);
        bus.ap_start = 1'b1; bus.base_addr = base; bus.total_beats = total; bus.max_burst = mb;
        #1;
        checks++;
        if ({bus.ap_ready, bus.ap_idle, bus.wr_valid} !== 3'b110) begin
            errors++;
            $display("FAIL %s accept: ready,idle,valid=%b want 110", tag,
                     {bus.ap_ready, bus.ap_idle, bus.wr_valid});
        end
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.base_addr = $urandom; bus.total_beats = $urandom; bus.max_burst = 16'($urandom);
        #1;
        checks++;
        if ({bus.ap_done, bus.ap_ready, bus.ap_idle, bus.wr_valid, bus.gen_start, bus.beats_done}
            !== {(total == 0), 4'b0000, 32'd0}) begin
            errors++;
            $display("FAIL %s cycle1: done,ready,idle,valid,start=%b beats_done=%0d want done=%b",
                     tag, {bus.ap_done, bus.ap_ready, bus.ap_idle, bus.wr_valid, bus.gen_start},
                     bus.beats_done, (total == 0));
        end
        acc = 0;
        for (int b = 0; b < exp_addr.size(); b++) begin
            len  = exp_len[b];
            last = (b == exp_addr.size() - 1);
            d = $urandom_range(w_hi, w_lo);
            for (int k = 0; k <= d; k++) begin
                @(negedge ap_clk);
                bus.wr_ready  = (k == d);
                bus.gen_done  = 1'($urandom_range(0, 1));
                bus.gen_ready = 1'($urandom_range(0, 1));
                bus.ap_start  = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_done} !== 4'b1000) begin
                    errors++;
                    $display("FAIL %s cmd ctl b%0d: valid,start,ready,done=%b want 1000", tag, b,
                             {bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_done});
                end
                checks++;
                if ({bus.wr_addr, bus.wr_beats, bus.gen_size} !== {exp_addr[b], len[15:0], len}) begin
                    errors++;
                    $display("FAIL %s cmd b%0d: addr=%h beats=%0d size=%0d want %h %0d %0d", tag, b,
                             bus.wr_addr, bus.wr_beats, bus.gen_size, exp_addr[b], len, len);
                end
            end
            checks++;
            if ((bus.wr_addr % 4096) + 32'(bus.wr_beats) * BYTES > 4096) begin
                errors++;
                $display("FAIL %s 4k b%0d: addr=%h beats=%0d crosses page", tag, b,
                         bus.wr_addr, bus.wr_beats);
            end
            d    = $urandom_range(g_hi, g_lo);
            same = (same_mode == 2) ? 1'($urandom_range(0, 1)) : (same_mode == 1);
            for (int k = 0; k <= d; k++) begin
                @(negedge ap_clk);
                bus.wr_ready  = 1'($urandom_range(0, 1));
                bus.gen_ready = (k == d);
                bus.gen_done  = (k == d) && same;
                bus.ap_start  = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_done} !== 4'b0100) begin
                    errors++;
                    $display("FAIL %s gen_start b%0d k%0d: valid,start,ready,done=%b want 0100", tag,
                             b, k, {bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_done});
                end
            end
            if (!same) begin
                d = $urandom_range(0, 3);
                for (int k = 0; k <= d; k++) begin
                    @(negedge ap_clk);
                    bus.wr_ready  = 1'($urandom_range(0, 1));
                    bus.gen_ready = 1'($urandom_range(0, 1));
                    bus.gen_done  = (k == d);
                    bus.ap_start  = 1'($urandom_range(0, 1));
                    #1;
                    checks++;
                    if ({bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_done} !== 4'b0000) begin
                        errors++;
                        $display("FAIL %s gen_wait b%0d: valid,start,ready,done=%b want 0000", tag,
                                 b, {bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_done});
                    end
                end
            end
            acc = acc + len;
            @(negedge ap_clk);
            bus.wr_ready = 1'b0; bus.gen_ready = 1'b0; bus.gen_done = 1'b0;
            bus.ap_start = last ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({bus.ap_done, bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_idle, bus.beats_done}
                !== {last, 4'b0000, acc}) begin
                errors++;
                $display("FAIL %s after b%0d: done,valid,start,ready,idle=%b beats_done=%0d want done=%b %0d",
                         tag, b, {bus.ap_done, bus.wr_valid, bus.gen_start, bus.ap_ready, bus.ap_idle},
                         bus.beats_done, last, acc);
            end
        end
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        #1;
        checks++;
        if ({bus.ap_idle, bus.ap_done, bus.wr_valid, bus.gen_start, bus.beats_done}
            !== {4'b1000, total}) begin
            errors++;
            $display("FAIL %s end: idle,done,valid,start=%b beats_done=%0d want 1000 %0d", tag,
                     {bus.ap_idle, bus.ap_done, bus.wr_valid, bus.gen_start}, bus.beats_done, total);
        end
    endtask

    task automatic test_reset();
        bus.ap_start = 0; bus.base_addr = 0; bus.total_beats = 0; bus.max_burst = 0;
        bus.wr_ready = 0; bus.gen_ready = 0; bus.gen_done = 0;
        ap_rst_n = 1'b0;
        #3;
        checks++;
        if ({bus.ap_ready, bus.ap_done, bus.ap_idle, bus.wr_valid, bus.gen_start, bus.wr_addr,
             bus.wr_beats, bus.gen_size, bus.beats_done} !== {5'b00100, 112'd0}) begin
            errors++;
            $display("FAIL reset: ctl=%b addr=%h beats=%0d size=%0d done=%0d want 00100 and zeros",
                     {bus.ap_ready, bus.ap_done, bus.ap_idle, bus.wr_valid, bus.gen_start},
                     bus.wr_addr, bus.wr_beats, bus.gen_size, bus.beats_done);
        end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_split();
        run_job(32'h0, 10, 4, 0, 0, 0, 0, 0, "split");
        run_job(32'h0, 10, 4, 0, 2, 0, 2, 1, "split_same");
    endtask

    task automatic test_4k_boundary();
        run_job(32'hFF0, 8, 256, 0, 1, 0, 1, 0, "4k");
        run_job(32'h1FFC, 3, 1000, 0, 0, 0, 0, 2, "4k_last");
    endtask

    task automatic test_zero_len();
        run_job(32'h40, 0, 4, 0, 0, 0, 0, 0, "zero");
    endtask

    task automatic test_default_cap();
        run_job(32'h0, 300, 0, 0, 0, 0, 0, 0, "cap0");
        run_job(32'h0, 300, 300, 0, 0, 0, 0, 1, "cap_big");
    endtask

    task automatic test_back_to_back();
        run_job(32'h100, 9, 4, 5, 5, 3, 3, 0, "backpressure");
        run_job(32'h200, 12, 4, 0, 0, 0, 0, 1, "same_cycle");
        run_job(32'hFFFF_FFF8, 5, 8, 0, 1, 0, 1, 2, "wrap");
    endtask

    task automatic test_reset_mid_job();
        int seen;
        @(negedge ap_clk);
        bus.ap_start = 1; bus.base_addr = 0; bus.total_beats = 12; bus.max_burst = 4;
        bus.wr_ready = 1; bus.gen_ready = 1; bus.gen_done = 1;
        @(negedge ap_clk);
        bus.ap_start = 0;
        seen = 0;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            @(negedge ap_clk);
            #1;
            if (bus.wr_valid) seen++;
        end
        checks++;
        if (seen != 2 || bus.wr_addr !== 32'h10 || bus.beats_done !== 32'd4) begin
            errors++;
            $display("FAIL midrst_burst2: seen=%0d addr=%h beats_done=%0d want 2 00000010 4",
                     seen, bus.wr_addr, bus.beats_done);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ap_ready, bus.ap_done, bus.ap_idle, bus.wr_valid, bus.gen_start, bus.wr_addr,
             bus.wr_beats, bus.gen_size, bus.beats_done} !== {5'b00100, 112'd0}) begin
            errors++;
            $display("FAIL midrst: ctl=%b addr=%h beats=%0d size=%0d done=%0d want 00100 and zeros",
                     {bus.ap_ready, bus.ap_done, bus.ap_idle, bus.wr_valid, bus.gen_start},
                     bus.wr_addr, bus.wr_beats, bus.gen_size, bus.beats_done);
        end
        @(negedge ap_clk);
        bus.wr_ready = 0; bus.gen_ready = 0; bus.gen_done = 0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        #1;
        checks++;
        if ({bus.ap_idle, bus.wr_valid, bus.gen_start} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_release: idle,valid,start=%b want 100",
                     {bus.ap_idle, bus.wr_valid, bus.gen_start});
        end
        run_job(32'h2000_0100, 7, 3, 0, 1, 0, 1, 2, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] base, total;
        logic [15:0] mb;
        for (int j = 0; j < 20; j++) begin
            base  = ($urandom_range(0, 2) == 0)
                    ? (32'($urandom_range(1, 9)) * 32'h1000 - 32'($urandom_range(0, 40)) * 4)
                    : ($urandom & 32'hFFFF_FFFC);
            total = (j % 7 == 3) ? 32'd0 : 32'($urandom_range(1, 300));
            case ($urandom_range(0, 3))
                0:       mb = 16'd0;
                1:       mb = 16'($urandom_range(257, 65535));
                default: mb = 16'($urandom_range(1, 256));
            endcase
            run_job(base, total, mb, 0, 3, 0, 3, 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_split();
        test_4k_boundary();
        test_zero_len();
        test_default_cap();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
